// File: rtl/writeback_regfile_pkg.sv
// Shared CPU state/opcode encodings and register-file sizing for the writeback stage.
// Used by every file of writeback_regfile (optional WB_BYPASS_EN forwarding lives in the top).
package writeback_regfile_pkg;

    typedef enum logic [2:0] {
        STATE_IF  = 3'd0,
        STATE_ID  = 3'd1,
        STATE_EX  = 3'd2,
        STATE_MEM = 3'd3,
        STATE_WB  = 3'd4
    } cpu_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/writeback_regfile_if.sv
// Bus between the multi-cycle CPU control/datapath and the writeback register file.
// The CPU side uses the master modport, the register file the slave modport.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic [2:0]            state;
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DW-1:0]         alu_result;
    logic [DW-1:0]         result_lw;
    logic [REG_ADDR_W-1:0] rs_raddr;
    logic [REG_ADDR_W-1:0] rt_raddr;
    logic [DW-1:0]         rs_rdata;
    logic [DW-1:0]         rt_rdata;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [CNT_W-1:0]      wb_count;

    modport master (
        output state, opcode, rt_addr, rd_addr, alu_result, result_lw, rs_raddr, rt_raddr,
        input  rs_rdata, rt_rdata, wb_valid, wb_dest, wb_count
    );

    modport slave (
        input  state, opcode, rt_addr, rd_addr, alu_result, result_lw, rs_raddr, rt_raddr,
        output rs_rdata, rt_rdata, wb_valid, wb_dest, wb_count
    );

endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// NREGS x DW register storage: two asynchronous read ports, one synchronous write port,
// asynchronous clear, register 0 reads as zero and is never written.
module regfile_2r1w
    import writeback_regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [REG_ADDR_W-1:0] raddrA_i,
    input  logic [REG_ADDR_W-1:0] raddrB_i,
    output logic [DW-1:0]         rdataA_o,
    output logic [DW-1:0]         rdataB_o
);

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = (raddrA_i == '0) ? '0 : mem_q[raddrA_i];
    assign rdataB_o = (raddrB_i == '0) ? '0 : mem_q[raddrB_i];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage of the multi-cycle CPU: commits load or ALU results into the register file
// in STATE_WB and counts commits. Define WB_BYPASS_EN to forward the commit data to the read ports.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_regfile_if.slave  bus
);

    logic                  commitWe;
    logic [REG_ADDR_W-1:0] commitAddr;
    logic [DW-1:0]         commitData;
    logic [DW-1:0]         rsStored;
    logic [DW-1:0]         rtStored;

    logic                  wbValid_q;
    logic [REG_ADDR_W-1:0] wbDest_q;
    logic [REG_ADDR_W-1:0] wbDest_d;
    logic [CNT_W-1:0]      wbCount_q;
    logic [CNT_W-1:0]      wbCount_d;

    // A commit is any writing opcode seen in STATE_WB, even when it targets r0.
    always_comb begin
        commitWe   = 1'b0;
        commitAddr = '0;
        commitData = '0;
        if (bus.state == STATE_WB) begin
            case (bus.opcode)
                OP_LW: begin
                    commitWe   = 1'b1;
                    commitAddr = bus.rt_addr;
                    commitData = bus.result_lw;
                end
                OP_ADDI: begin
                    commitWe   = 1'b1;
                    commitAddr = bus.rt_addr;
                    commitData = bus.alu_result;
                end
                OP_RTYPE: begin
                    commitWe   = 1'b1;
                    commitAddr = bus.rd_addr;
                    commitData = bus.alu_result;
                end
                default: begin
                    commitWe   = 1'b0;
                end
            endcase
        end
    end

    regfile_2r1w #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (commitWe),
        .waddr_i  (commitAddr),
        .wdata_i  (commitData),
        .raddrA_i (bus.rs_raddr),
        .raddrB_i (bus.rt_raddr),
        .rdataA_o (rsStored),
        .rdataB_o (rtStored)
    );

`ifdef WB_BYPASS_EN
    always_comb begin
        bus.rs_rdata = rsStored;
        bus.rt_rdata = rtStored;
        if (commitWe && (commitAddr != '0)) begin
            if (bus.rs_raddr == commitAddr) bus.rs_rdata = commitData;
            if (bus.rt_raddr == commitAddr) bus.rt_rdata = commitData;
        end
    end
`else
    assign bus.rs_rdata = rsStored;
    assign bus.rt_rdata = rtStored;
`endif

    // Counter saturates at all-ones rather than wrapping.
    always_comb begin
        wbDest_d  = commitWe ? commitAddr : wbDest_q;
        wbCount_d = wbCount_q;
        if (commitWe && (wbCount_q != '1)) begin
            wbCount_d = wbCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValid_q <= 1'b0;
            wbDest_q  <= '0;
            wbCount_q <= '0;
        end else begin
            wbValid_q <= commitWe;
            wbDest_q  <= wbDest_d;
            wbCount_q <= wbCount_d;
        end
    end

    assign bus.wb_valid = wbValid_q;
    assign bus.wb_dest  = wbDest_q;
    assign bus.wb_count = wbCount_q;

endmodule
